// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin write arbiter.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  // Width of the cooldown counter; enough for HOLDOFF values up to 15.
  localparam int HOLDOFF_W = 4;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/dff_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above the
// pointer, wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eff_req,
  input  logic [IDX_W-1:0]   pointer,
  output logic               any_valid,
  output logic [IDX_W-1:0]   pick_idx
);

  // cand_idx[k] is the requester examined at scan position k from the pointer.
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    // Pointer is always below NUM_REQ, so one conditional subtract wraps it.
    assign sum           = {1'b0, pointer} + (IDX_W + 1)'(gi);
    assign cand_idx[gi]  = (sum >= (IDX_W + 1)'(NUM_REQ)) ?
                           IDX_W'(sum - (IDX_W + 1)'(NUM_REQ)) : IDX_W'(sum);
    assign cand_hit[gi]  = eff_req[cand_idx[gi]];
  end

  // Scan from the far end so the candidate closest to the pointer wins.
  always_comb begin
    any_valid = |cand_hit;
    pick_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) pick_idx = cand_idx[k];
    end
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter serialising NUM_REQ writers onto one shared
// q / q_n register pair, with a clear path that overrides writes.
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter  int BITS_COUNT = 7,
  parameter  int NUM_REQ    = 4,
  parameter  int HOLDOFF    = 0,
  localparam int IDX_W      = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*BITS_COUNT-1:0] wdata,
  input  logic                          clr,
  output logic [NUM_REQ-1:0]            ack,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic [BITS_COUNT-1:0]         q,
  output logic [BITS_COUNT-1:0]         q_n
);

  state_e                state_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      grant_id_q;
  logic [BITS_COUNT-1:0] wbuf_q;
  logic [BITS_COUNT-1:0] store_q;
  logic [BITS_COUNT-1:0] store_n_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic                  busy_q;
  logic [HOLDOFF_W-1:0]  cnt_q;

  logic [BITS_COUNT-1:0] wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    eff_req;
  logic [NUM_REQ-1:0]    ack_d;
  logic [IDX_W-1:0]      ptr_d;
  logic                  any_valid;
  logic [IDX_W-1:0]      pick_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign wdata_arr[gi] = wdata[gi*BITS_COUNT +: BITS_COUNT];
    // One-hot ack for the requester currently holding the grant.
    assign ack_d[gi]     = (grant_id_q == IDX_W'(gi));
  end

  // A requester in its own ack cycle is masked so a late deassert
  // cannot win a second grant.
  assign eff_req = req & ~ack_q;

  // Pointer advances to the slot just after the committed writer.
  assign ptr_d = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .eff_req   (eff_req),
    .pointer   (ptr_q),
    .any_valid (any_valid),
    .pick_idx  (pick_idx)
  );

  // Arbitration FSM with storage, ack and busy all registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      wbuf_q     <= '0;
      store_q    <= '0;
      store_n_q  <= '1;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (clr) begin
            store_q   <= '0;
            store_n_q <= '1;
          end else if (any_valid) begin
            grant_id_q <= pick_idx;
            wbuf_q     <= wdata_arr[pick_idx];
            state_q    <= WRITE;
            busy_q     <= 1'b1;
          end
        end
        WRITE: begin
          if (!clr) begin
            store_q   <= wbuf_q;
            store_n_q <= ~wbuf_q;
            ack_q     <= ack_d;
            ptr_q     <= ptr_d;
          end else begin
            // Aborted write: the requester stays pending and is re-arbitrated.
            store_q   <= '0;
            store_n_q <= '1;
          end
          if (HOLDOFF > 0) begin
            state_q <= COOLDOWN;
            cnt_q   <= HOLDOFF_W'(HOLDOFF - 1);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        COOLDOWN: begin
          if (clr) begin
            store_q   <= '0;
            store_n_q <= '1;
          end
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q        = store_q;
  assign q_n      = store_n_q;
  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed testbench for dff_write_arbiter: one HOLDOFF=0 instance and
// one HOLDOFF=3 instance sharing a clock.
module tb_dff_write_arbiter;

  logic        clk;
  logic        rst, clr;
  logic [3:0]  req;
  logic [27:0] wdata;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic [6:0]  q, q_n;

  logic        h_rst, h_clr;
  logic [3:0]  h_req;
  logic [27:0] h_wdata;
  logic [3:0]  h_ack;
  logic [1:0]  h_gid;
  logic        h_busy;
  logic [6:0]  h_q, h_qn;

  int total = 0;
  int bad   = 0;

  dff_write_arbiter #(.BITS_COUNT(7), .NUM_REQ(4), .HOLDOFF(0)) u_dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .clr(clr),
    .ack(ack), .grant_id(grant_id), .busy(busy), .q(q), .q_n(q_n)
  );

  dff_write_arbiter #(.BITS_COUNT(7), .NUM_REQ(4), .HOLDOFF(3)) u_dut_h (
    .clk(clk), .rst(h_rst), .req(h_req), .wdata(h_wdata), .clr(h_clr),
    .ack(h_ack), .grant_id(h_gid), .busy(h_busy), .q(h_q), .q_n(h_qn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] exp_v;
    rst = 1'b1; h_rst = 1'b1; clr = 1'b0; h_clr = 1'b0;
    req = '0; h_req = '0; wdata = '0; h_wdata = '0;
    #1;
    exp_v = {7'h00, 7'h7F, 4'b0000, 1'b0};
    total++;
    if ({q, q_n, ack, busy} !== exp_v || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got=%h/%0d exp=%h/0", {q, q_n, ack, busy}, grant_id, exp_v);
    end
    total++;
    if ({h_q, h_qn, h_ack, h_busy} !== exp_v) begin
      bad++;
      $display("FAIL reset_state_h got=%h exp=%h", {h_q, h_qn, h_ack, h_busy}, exp_v);
    end
    tick(); tick();
    rst = 1'b0; h_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({q, q_n, ack, busy} !== exp_v) begin
        bad++;
        $display("FAIL idle_cycle%0d got=%h exp=%h", i, {q, q_n, ack, busy}, exp_v);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    req = 4'b0100; wdata[2*7 +: 7] = 7'h55;
    tick();
    total++;
    if ({grant_id, busy, ack, q} !== {2'd2, 1'b1, 4'b0000, 7'h00}) begin
      bad++;
      $display("FAIL single_grant got=%h exp=%h", {grant_id, busy, ack, q}, {2'd2, 1'b1, 4'b0000, 7'h00});
    end
    tick();
    total++;
    if ({q, q_n, ack, busy} !== {7'h55, 7'h2A, 4'b0100, 1'b0}) begin
      bad++;
      $display("FAIL single_commit got=%h exp=%h", {q, q_n, ack, busy}, {7'h55, 7'h2A, 4'b0100, 1'b0});
    end
    tick();
    total++;
    if ({ack, busy, q} !== {4'b0000, 1'b0, 7'h55}) begin
      bad++;
      $display("FAIL single_no_rewrite got=%h exp=%h", {ack, busy, q}, {4'b0000, 1'b0, 7'h55});
    end
    req = '0;
    tick();
    $display("test_single done q=%h", q);
  endtask

  task automatic test_fairness();
    logic [6:0] fdat [4];
    logic [6:0] d;
    fdat[0] = 7'h11; fdat[1] = 7'h22; fdat[2] = 7'h33; fdat[3] = 7'h44;
    rst = 1'b1; #2; rst = 1'b0;
    for (int i = 0; i < 4; i++) wdata[i*7 +: 7] = fdat[i];
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      d = fdat[r % 4];
      tick();
      total++;
      if ({grant_id, busy} !== {2'(r % 4), 1'b1}) begin
        bad++;
        $display("FAIL fair_grant%0d got=%h exp=%h", r, {grant_id, busy}, {2'(r % 4), 1'b1});
      end
      tick();
      total++;
      if ({q, q_n, ack} !== {d, ~d, 4'(1 << (r % 4))}) begin
        bad++;
        $display("FAIL fair_commit%0d got=%h exp=%h", r, {q, q_n, ack}, {d, ~d, 4'(1 << (r % 4))});
      end
      $display("fair round %0d q=%h ack=%b", r, q, ack);
    end
    req = '0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL fair_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_clear();
    req = 4'b0010; wdata[1*7 +: 7] = 7'h3C;
    tick();
    total++;
    if ({grant_id, busy} !== {2'd1, 1'b1}) begin
      bad++;
      $display("FAIL clr_grant got=%h exp=%h", {grant_id, busy}, {2'd1, 1'b1});
    end
    clr = 1'b1;
    tick();
    total++;
    if ({q, q_n, ack, busy} !== {7'h00, 7'h7F, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL clr_abort got=%h exp=%h", {q, q_n, ack, busy}, {7'h00, 7'h7F, 4'b0000, 1'b0});
    end
    clr = 1'b0;
    tick();
    total++;
    if ({grant_id, busy} !== {2'd1, 1'b1}) begin
      bad++;
      $display("FAIL clr_regrant got=%h exp=%h", {grant_id, busy}, {2'd1, 1'b1});
    end
    wdata[1*7 +: 7] = 7'h01;
    tick();
    total++;
    if ({q, q_n, ack} !== {7'h3C, 7'h43, 4'b0010}) begin
      bad++;
      $display("FAIL clr_recommit got=%h exp=%h", {q, q_n, ack}, {7'h3C, 7'h43, 4'b0010});
    end
    req = '0;
    tick();
    $display("test_clear done q=%h", q);
  endtask

  task automatic test_drop();
    req = 4'b1001; wdata[3*7 +: 7] = 7'h5A; wdata[0 +: 7] = 7'h12;
    tick();
    total++;
    if ({grant_id, busy} !== {2'd3, 1'b1}) begin
      bad++;
      $display("FAIL drop_grant got=%h exp=%h", {grant_id, busy}, {2'd3, 1'b1});
    end
    req = '0;
    tick();
    total++;
    if ({q, q_n, ack} !== {7'h5A, 7'h25, 4'b1000}) begin
      bad++;
      $display("FAIL drop_commit got=%h exp=%h", {q, q_n, ack}, {7'h5A, 7'h25, 4'b1000});
    end
    tick();
    tick();
    total++;
    if ({busy, ack, q} !== {1'b0, 4'b0000, 7'h5A}) begin
      bad++;
      $display("FAIL drop_no_write got=%h exp=%h", {busy, ack, q}, {1'b0, 4'b0000, 7'h5A});
    end
    $display("test_drop done q=%h", q);
  endtask

  task automatic test_holdoff();
    h_req = 4'b0011; h_wdata[0 +: 7] = 7'h0A; h_wdata[7 +: 7] = 7'h0B;
    tick();
    total++;
    if ({h_gid, h_busy} !== {2'd0, 1'b1}) begin
      bad++;
      $display("FAIL hold_grant0 got=%h exp=%h", {h_gid, h_busy}, {2'd0, 1'b1});
    end
    tick();
    total++;
    if ({h_q, h_qn, h_ack, h_busy} !== {7'h0A, 7'h75, 4'b0001, 1'b1}) begin
      bad++;
      $display("FAIL hold_commit0 got=%h exp=%h", {h_q, h_qn, h_ack, h_busy}, {7'h0A, 7'h75, 4'b0001, 1'b1});
    end
    h_req = 4'b0010;
    tick();
    total++;
    if ({h_ack, h_busy, h_q} !== {4'b0000, 1'b1, 7'h0A}) begin
      bad++;
      $display("FAIL hold_cool1 got=%h exp=%h", {h_ack, h_busy, h_q}, {4'b0000, 1'b1, 7'h0A});
    end
    h_clr = 1'b1;
    tick();
    total++;
    if ({h_q, h_qn, h_busy} !== {7'h00, 7'h7F, 1'b1}) begin
      bad++;
      $display("FAIL hold_cool_clr got=%h exp=%h", {h_q, h_qn, h_busy}, {7'h00, 7'h7F, 1'b1});
    end
    h_clr = 1'b0;
    tick();
    total++;
    if (h_busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_idle got=%b exp=0", h_busy);
    end
    tick();
    total++;
    if ({h_gid, h_busy} !== {2'd1, 1'b1}) begin
      bad++;
      $display("FAIL hold_grant1 got=%h exp=%h", {h_gid, h_busy}, {2'd1, 1'b1});
    end
    tick();
    total++;
    if ({h_q, h_qn, h_ack} !== {7'h0B, 7'h74, 4'b0010}) begin
      bad++;
      $display("FAIL hold_commit1 got=%h exp=%h", {h_q, h_qn, h_ack}, {7'h0B, 7'h74, 4'b0010});
    end
    h_req = '0;
    tick();
    $display("test_holdoff done q=%h", h_q);
  endtask

  task automatic test_async_reset();
    req = 4'b0100; wdata[2*7 +: 7] = 7'h77;
    tick();
    tick();
    total++;
    if ({q, q_n, ack} !== {7'h77, 7'h08, 4'b0100}) begin
      bad++;
      $display("FAIL ares_pre got=%h exp=%h", {q, q_n, ack}, {7'h77, 7'h08, 4'b0100});
    end
    req = 4'b1001; wdata[3*7 +: 7] = 7'h66; wdata[0 +: 7] = 7'h12;
    tick();
    total++;
    if ({grant_id, busy} !== {2'd3, 1'b1}) begin
      bad++;
      $display("FAIL ares_grant3 got=%h exp=%h", {grant_id, busy}, {2'd3, 1'b1});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({q, q_n, ack, busy, grant_id} !== {7'h00, 7'h7F, 4'b0000, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL ares_immediate got=%h exp=%h", {q, q_n, ack, busy, grant_id}, {7'h00, 7'h7F, 4'b0000, 1'b0, 2'd0});
    end
    #3;
    rst = 1'b0;
    tick();
    total++;
    if ({grant_id, busy} !== {2'd0, 1'b1}) begin
      bad++;
      $display("FAIL ares_ptr0 got=%h exp=%h", {grant_id, busy}, {2'd0, 1'b1});
    end
    tick();
    total++;
    if ({q, ack} !== {7'h12, 4'b0001}) begin
      bad++;
      $display("FAIL ares_commit0 got=%h exp=%h", {q, ack}, {7'h12, 4'b0001});
    end
    req = 4'b1000;
    tick();
    tick();
    total++;
    if ({q, q_n, ack} !== {7'h66, 7'h19, 4'b1000}) begin
      bad++;
      $display("FAIL ares_commit3 got=%h exp=%h", {q, q_n, ack}, {7'h66, 7'h19, 4'b1000});
    end
    req = '0;
    tick();
    $display("test_async_reset done q=%h", q);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_clear();
    test_drop();
    test_holdoff();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
